// File: rtl/risc_v_bpu_pkg.sv
// Branch predictor shared definitions: 2-bit counter encoding
// and the saturating counter update.
package risc_v_bpu_pkg;

  localparam logic [1:0] BPU_SNT = 2'd0;
  localparam logic [1:0] BPU_WNT = 2'd1;
  localparam logic [1:0] BPU_WT = 2'd2;
  localparam logic [1:0] BPU_ST = 2'd3;
  localparam logic [1:0] BPU_INIT = BPU_WT;

  function automatic logic [1:0] bpu_next(
    input logic [1:0] ctr,
    input logic taken
  );
    if (taken)
      return (ctr == BPU_ST) ? BPU_ST : ctr + 2'd1;
    return (ctr == BPU_SNT) ? BPU_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/risc_v_btb.sv
// Direct-mapped branch target buffer: combinational fetch lookup,
// one synchronous write port driven by the Execute resolution.
module risc_v_btb
  import risc_v_bpu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rd_pc,
  output logic            hit,
  output logic [1:0]      ctr,
  output logic [XLEN-1:0] target,
  input  logic            upd_en,
  input  logic            inv_en,
  input  logic [XLEN-1:0] wr_pc,
  input  logic            taken,
  input  logic [XLEN-1:0] wr_target
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = XLEN - IW - 2;

  logic [ENTRIES-1:0] valid;
  logic [TW-1:0]      tags    [ENTRIES];
  logic [XLEN-1:0]    targets [ENTRIES];
  logic [1:0]         ctrs    [ENTRIES];

  logic [IW-1:0] ri;
  logic [IW-1:0] wi;
  logic [TW-1:0] rt;
  logic [TW-1:0] wt;
  logic          w_hit;
  logic          alloc;

  assign ri = rd_pc[IW+1:2];
  assign rt = rd_pc[XLEN-1:IW+2];
  assign wi = wr_pc[IW+1:2];
  assign wt = wr_pc[XLEN-1:IW+2];

  assign hit = valid[ri] && (tags[ri] == rt);
  assign ctr = ctrs[ri];
  assign target = targets[ri];

  assign w_hit = valid[wi] && (tags[wi] == wt);
  assign alloc = upd_en && !w_hit && taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (alloc) begin
      valid[wi] <= 1'b1;
    end else if (inv_en && w_hit) begin
      valid[wi] <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (upd_en && w_hit) begin
      ctrs[wi] <= bpu_next(ctrs[wi], taken);
      if (taken)
        targets[wi] <= wr_target;
    end else if (alloc) begin
      tags[wi] <= wt;
      targets[wi] <= wr_target;
      ctrs[wi] <= BPU_INIT;
    end
  end

endmodule

// File: rtl/risc_v_fetch_predictor.sv
// Fetch PC unit: PC register, BTB-driven next-PC prediction and
// Execute-stage mispredict detection with redirect.
module risc_v_fetch_predictor
  import risc_v_bpu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  output logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic            ValidE,
  input  logic            CfiE,
  input  logic [XLEN-1:0] PCE,
  input  logic            TakenE,
  input  logic [XLEN-1:0] TargetE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  output logic            RedirectE,
  output logic [XLEN-1:0] RedirectPCE
);

  logic            hit_f;
  logic [1:0]      ctr_f;
  logic [XLEN-1:0] tgt_f;
  logic [XLEN-1:0] pc_next;
  logic            taken_cfi;

  risc_v_btb #(
    .XLEN(XLEN),
    .ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk(clk),
    .rst(rst),
    .rd_pc(PCF),
    .hit(hit_f),
    .ctr(ctr_f),
    .target(tgt_f),
    .upd_en(ValidE && CfiE),
    .inv_en(ValidE && !CfiE),
    .wr_pc(PCE),
    .taken(TakenE),
    .wr_target(TargetE)
  );

  assign PredTakenF = hit_f && ctr_f[1];
  assign PredTargetF = PredTakenF ? tgt_f : PCF + XLEN'(4);

  // A non-CFI that was predicted taken is an alias and mispredicts.
  assign taken_cfi = CfiE && TakenE;
  assign RedirectE = ValidE &&
    ((PredTakenE != taken_cfi) ||
     (PredTakenE && (PredTargetE != TargetE)));
  assign RedirectPCE = TakenE ? TargetE : PCE + XLEN'(4);

  always_comb begin
    pc_next = PredTargetF;
    if (RedirectE)
      pc_next = RedirectPCE;
    else if (StallF)
      pc_next = PCF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      PCF <= RESET_PC;
    else
      PCF <= pc_next;
  end

endmodule
